// File: rtl/hd_pkg.sv
// Shared types and constants for the HD serial link (transmit and receive ends).
package hd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} hd_tx_state_t;

    localparam int unsigned HD_HIST_DEPTH = 3;
    localparam int unsigned HD_WIDTH      = 8;

endpackage

// File: rtl/hd_piso.sv
// Parallel-in serial-out register: loads a word and presents its head bit, shifting
// zeros in behind so the head reads 0 once the word is drained.
module hd_piso
    import hd_pkg::*;
#(
    parameter int unsigned WIDTH     = HD_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_shift,
    output logic             o_head
);

    logic [WIDTH-1:0] r_sreg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sreg <= '0;
        end else if (i_load) begin
            r_sreg <= i_data;
        end else if (i_shift) begin
            r_sreg <= MSB_FIRST ? {r_sreg[WIDTH-2:0], 1'b0} : {1'b0, r_sreg[WIDTH-1:1]};
        end
    end

    assign o_head = MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0];

endmodule

// File: rtl/hd_valid_tx.sv
// HD link transmitter: accepts words over valid/ready and sends each as a WIDTH-cycle
// hd_valid burst, separated by GAP low cycles so the receiver always sees a rising edge.
module hd_valid_tx
    import hd_pkg::*;
#(
    parameter int unsigned WIDTH     = HD_WIDTH,
    parameter int unsigned GAP       = 2,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_s_data,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    output logic             o_hd_data,
    output logic             o_hd_valid,
    output logic             o_hd_last,
    output logic             o_busy
);

    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
        $error("hd_valid_tx: WIDTH must be in 2..64");
    end
    if (GAP < 1 || GAP > 15) begin : g_bad_gap
        $error("hd_valid_tx: GAP must be in 1..15");
    end

    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] BitLoad = CntW'(WIDTH - 1);
    localparam logic [3:0]      GapLoad = (GAP >= 2) ? 4'(GAP - 2) : 4'd0;

    // The GAP parameter hides the enumerator of the same name, hence hd_pkg::GAP below.
    hd_tx_state_t    r_state, w_state_nxt;
    logic [CntW-1:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [3:0]      r_gap_cnt, w_gap_cnt_nxt;
    logic            r_s_ready, r_hd_valid, r_hd_last, r_busy;
    logic            w_load, w_shift, w_head;

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_load        = 1'b0;
        w_shift       = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_s_valid && r_s_ready) begin
                    w_load        = 1'b1;
                    w_bit_cnt_nxt = BitLoad;
                    w_state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                w_shift = 1'b1;
                if (r_bit_cnt == '0) begin
                    if (GAP == 1) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt   = hd_pkg::GAP;
                        w_gap_cnt_nxt = GapLoad;
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt - 1'b1;
                end
            end
            hd_pkg::GAP: begin
                if (r_gap_cnt == 4'd0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 4'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_gap_cnt  <= 4'd0;
            r_s_ready  <= 1'b0;
            r_hd_valid <= 1'b0;
            r_hd_last  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_s_ready  <= (w_state_nxt == IDLE);
            r_hd_valid <= (w_state_nxt == SHIFT);
            r_hd_last  <= (w_state_nxt == SHIFT) && (w_bit_cnt_nxt == '0);
            r_busy     <= (w_state_nxt != IDLE);
        end
    end

    hd_piso #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_load),
        .i_data  (i_s_data),
        .i_shift (w_shift),
        .o_head  (w_head)
    );

    assign o_s_ready  = r_s_ready;
    assign o_hd_data  = w_head;
    assign o_hd_valid = r_hd_valid;
    assign o_hd_last  = r_hd_last;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_hd_valid_tx.sv
// Randomized bench for hd_valid_tx over three configurations, checked cycle by cycle
// against a burst-timeline reference model plus a 3-deep receiver edge detector.
module tb_hd_valid_tx;
    import hd_pkg::*;

    localparam int NInst = 3;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    bit   done [NInst];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int unsigned cfg_w(input int k);
        return (k == 2) ? 5 : 8;
    endfunction
    function automatic int unsigned cfg_g(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 3;
    endfunction
    function automatic bit cfg_m(input int k);
        return (k != 1);
    endfunction

    for (genvar k = 0; k < NInst; k++) begin : g_inst
        localparam int unsigned W = cfg_w(k);
        localparam int unsigned G = cfg_g(k);
        localparam bit          M = cfg_m(k);

        logic         rst_n, s_valid, s_ready, hd_data, hd_valid, hd_last, busy;
        logic [W-1:0] s_data;

        hd_valid_tx #(
            .WIDTH     (W),
            .GAP       (G),
            .MSB_FIRST (M)
        ) u_dut (
            .i_clk      (clk),
            .i_rst_n    (rst_n),
            .i_s_data   (s_data),
            .i_s_valid  (s_valid),
            .o_s_ready  (s_ready),
            .o_hd_data  (hd_data),
            .o_hd_valid (hd_valid),
            .o_hd_last  (hd_last),
            .o_busy     (busy)
        );

        // Reference: one burst at a time, located by its accept cycle and word.
        int          rdy_cyc  = 1 << 30;
        int          last_acc = 1 << 30;
        int          burst_s  = -1000;
        int          frames   = 0;
        bit          in_rst   = 1'b1;
        logic [63:0] word     = '0;

        always @(negedge clk) begin
            int i;
            logic ev, ed, el, er, eb;
            if (!rst_n) begin
                check($sformatf("i%0d.rst_ready", k), s_ready, 0);
                check($sformatf("i%0d.rst_valid", k), hd_valid, 0);
                check($sformatf("i%0d.rst_data", k), hd_data, 0);
                check($sformatf("i%0d.rst_last", k), hd_last, 0);
                check($sformatf("i%0d.rst_busy", k), busy, 0);
                in_rst   = 1'b1;
                burst_s  = -1000;
                rdy_cyc  = 1 << 30;
                last_acc = 1 << 30;
            end else begin
                if (in_rst) begin
                    rdy_cyc  = cyc + 1;
                    last_acc = cyc;
                    in_rst   = 1'b0;
                end
                i  = cyc - burst_s - 1;
                ev = (i >= 0) && (i < int'(W));
                ed = ev ? (M ? word[int'(W) - 1 - i] : word[i]) : 1'b0;
                el = ev && (i == int'(W) - 1);
                er = (cyc >= rdy_cyc);
                eb = (cyc > last_acc) && (cyc < rdy_cyc);
                check($sformatf("i%0d.ready", k), s_ready, er);
                check($sformatf("i%0d.valid", k), hd_valid, ev);
                check($sformatf("i%0d.data", k), hd_data, ed);
                check($sformatf("i%0d.last", k), hd_last, el);
                check($sformatf("i%0d.busy", k), busy, eb);
                if (s_valid && er) begin
                    burst_s  = cyc;
                    word     = 64'(s_data);
                    last_acc = cyc;
                    rdy_cyc  = cyc + int'(W) + int'(G);
                    frames++;
                end
            end
        end

        // Receiver side: history register and rising-edge detector.
        logic [HD_HIST_DEPTH-1:0] hist  = '0;
        int                       edges = 0;

        always @(posedge clk) begin
            hist <= {hist[1:0], hd_valid};
            if (hist[1:0] == 2'b01) edges <= edges + 1;
        end

        // Entered and left at posedge+1; s_data holds junk on cycles the DUT is not ready.
        task automatic send(input logic [63:0] w);
            bit acc = 1'b0;
            s_valid = 1'b1;
            for (int n = 0; n < 200 && !acc; n++) begin
                acc    = s_ready;
                s_data = acc ? w[W-1:0] : W'({$urandom(), $urandom()});
                @(posedge clk);
                #1;
            end
            if (!acc) check($sformatf("i%0d.send_timeout", k), 0, 1);
        endtask

        task automatic idle(input int n);
            s_valid = 1'b0;
            repeat (n) begin
                @(posedge clk);
                #1;
            end
        endtask

        initial begin
            int g;
            rst_n   = 1'b0;
            s_valid = 1'b0;
            s_data  = '0;
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
            idle(3);

            send((k == 0) ? 64'hA5 : (k == 1) ? 64'h01 : {$urandom(), $urandom()});
            idle(12);

            send(64'hFF);
            send(64'h00);
            idle(12);

            for (int n = 0; n < 40; n++) begin
                send({$urandom(), $urandom()});
                g = $urandom_range(0, 3);
                if (g > 0) idle(g);
            end
            idle(12);

            // Truncate a burst after its third bit.
            send(64'hC3);
            s_valid = 1'b0;
            repeat (2) @(posedge clk);
            #3 rst_n = 1'b0;
            #1;
            check($sformatf("i%0d.async_valid", k), hd_valid, 0);
            check($sformatf("i%0d.async_last", k), hd_last, 0);
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            idle(2);
            send({$urandom(), $urandom()});
            idle(20);

            check($sformatf("i%0d.rx_edges", k), 64'(edges), 64'(frames));
            done[k] = 1'b1;
        end
    end

    initial begin
        bit all_done = 1'b0;
        for (int n = 0; n < 60000 && !all_done; n++) begin
            @(posedge clk);
            all_done = done[0] && done[1] && done[2];
        end
        if (!all_done) check("run_timeout", 0, 1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
